dense_mac_seq: RTL and testbench
================================

// Module: dense_mac_seq
// PURPOSE
//  Sequencer + MAC datapath for one fully-connected layer. Drives the weight ROM
//  (1-cycle registered read, en-gated) and the activation buffer (same latency).
//  Computes one dot product per output neuron and emits results on a
//  valid/ready stream to the activation stage downstream.
// PARAMETERS
//  IN_LEN     64   inputs per neuron (>=2)
//  OUT_LEN    10   output neurons (>=1)
//  W_W        16   signed weight width; ROM instantiated with RAM_WIDTH=W_W
//  A_W        16   signed activation width
//  ACC_W      40   signed accumulator width (>= W_W+A_W+clog2(IN_LEN))
//  FRAC       8    right-shift applied to accumulator before output
//  OUT_W      16   signed output width
//  BASE_ADDR  0    ROM word address of weight[0][0]
//  ROM_AW     19   ROM address width; ACT_AW = clog2(IN_LEN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        begin layer; sampled only in IDLE
//  busy       out  1        1 whenever state != IDLE
//  done       out  1        1-cycle pulse after last output accepted
//  rom_en     out  1        ROM read enable
//  rom_addr   out  ROM_AW   ROM address
//  rom_dout   in   W_W      ROM data, valid the cycle after rom_en
//  act_rd     out  1        activation buffer read enable
//  act_addr   out  ACT_AW   activation index
//  act_data   in   A_W      activation data, valid the cycle after act_rd
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accept
//  out_data   out  OUT_W    saturated result
//  out_idx    out  clog2(OUT_LEN)  neuron index of out_data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; acc, neuron cnt n, input cnt k cleared.
//  FSM: IDLE -> RUN -> FLUSH -> OUT -> (RUN | DONE) -> IDLE.
//  IDLE: start=1 -> RUN, n=0, k=0, acc=0. start ignored in every other state.
//  RUN (IN_LEN cycles): rom_en=act_rd=1; rom_addr=BASE_ADDR+n*IN_LEN+k;
//   act_addr=k; k++. At k==IN_LEN-1 -> FLUSH. Address arithmetic in ROM_AW bits.
//  MAC: registered valid bit tracks each issued read; on the following cycle
//   acc += sext(rom_dout)*sext(act_data), full ACC_W precision, no saturation.
//   Last product is accumulated at the edge closing FLUSH.
//  FLUSH (1 cycle): rom_en=act_rd=0; -> OUT.
//  OUT: out_valid=1, out_idx=n, out_data=sat(acc>>>FRAC) (arithmetic shift;
//   clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]). out_data/out_idx stable while
//   out_valid && !out_ready. No reads issued while stalled.
//   On out_valid&&out_ready: if n==OUT_LEN-1 -> DONE else n++, k=0, acc=0,
//   -> RUN (no bubble).
//  DONE (1 cycle): done=1, busy=1 -> IDLE.
//  Timing: start high in cycle 0 -> RUN cycles 1..IN_LEN, FLUSH IN_LEN+1,
//   first out_valid cycle IN_LEN+2; each neuron = IN_LEN+2 cycles with
//   out_ready held 1; done follows last accept by 1 cycle.
//  Reset mid-operation: immediate return to IDLE, outputs 0, partial results
//   discarded; next start begins from neuron 0.
// TESTING
//  1 IN_LEN=4,OUT_LEN=2,FRAC=0: ROM=1..8, acts=1,1,1,1, out_ready=1 -> out 10
//    (idx0) at cycle 6, 26 (idx1) at cycle 12, done at cycle 13.
//  2 Backpressure: out_ready=0 for 5 cycles at first OUT -> out_valid held,
//    out_data constant, rom_en=0 throughout; resumes on accept.
//  3 Saturation, OUT_W=16, FRAC=0: all W=A=0x7FFF, IN_LEN=4 -> out 0x7FFF;
//    W=0x8000, A=0x7FFF -> out 0x8000.
//  4 Sign/shift: FRAC=8, W=-256, A=1 x IN_LEN=4 -> acc=-1024, out=-4.
//  5 Reset asserted mid-RUN of neuron 1 -> all outputs 0 asynchronously; new
//    start yields idx0 result identical to test 1.
//  6 start pulsed while busy -> ignored; exactly OUT_LEN outputs, one done.

Source files
------------

// File: rtl/dense_mac_seq.sv
// Sequencer and MAC datapath for one fully-connected layer: streams weights and
// activations through a 1-cycle read pipeline and emits one saturated dot product per neuron.
module dense_mac_seq #(
    parameter int unsigned IN_LEN    = 64,
    parameter int unsigned OUT_LEN   = 10,
    parameter int unsigned W_W       = 16,
    parameter int unsigned A_W       = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ROM_AW    = 19,
    localparam int unsigned ACT_AW   = $clog2(IN_LEN),
    localparam int unsigned IDX_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_en_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [W_W-1:0]    rom_dout_i,
    output logic              act_rd_o,
    output logic [ACT_AW-1:0] act_addr_o,
    input  logic [A_W-1:0]    act_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [IDX_W-1:0]  out_idx_o
);

    localparam int unsigned PROD_W = W_W + A_W;
    localparam logic [ACT_AW-1:0] KLast = ACT_AW'(IN_LEN - 1);
    localparam logic [IDX_W-1:0] NLast = IDX_W'(OUT_LEN - 1);
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

    typedef enum logic [2:0] {StIdle, StRun, StFlush, StOut, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         n_q, n_d;
    logic [ACT_AW-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     mac_vld_q, mac_vld_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_shift;
    logic [OUT_W-1:0]         sat_data;

    // Operands widened to the product width so the multiply is exact and signed.
    assign prod = $signed({{A_W{rom_dout_i[W_W-1]}}, rom_dout_i})
                * $signed({{W_W{act_data_i[A_W-1]}}, act_data_i});
    assign acc_shift = acc_q >>> FRAC;

    always_comb begin
        sat_data = acc_shift[OUT_W-1:0];
        if (acc_shift > SatMax) begin
            sat_data = SatMax[OUT_W-1:0];
        end else if (acc_shift < SatMin) begin
            sat_data = SatMin[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        mac_vld_d   = 1'b0;
        busy_o      = (state_q != StIdle);
        done_o      = 1'b0;
        rom_en_o    = 1'b0;
        rom_addr_o  = '0;
        act_rd_o    = 1'b0;
        act_addr_o  = '0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_idx_o   = '0;

        // Data returned for the read issued last cycle.
        if (mac_vld_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            StRun: begin
                rom_en_o   = 1'b1;
                act_rd_o   = 1'b1;
                rom_addr_o = ROM_AW'(BASE_ADDR) + ROM_AW'(n_q) * ROM_AW'(IN_LEN) + ROM_AW'(k_q);
                act_addr_o = k_q;
                mac_vld_d  = 1'b1;
                k_d        = k_q + ACT_AW'(1);
                if (k_q == KLast) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StOut;
            end
            StOut: begin
                out_valid_o = 1'b1;
                out_idx_o   = n_q;
                out_data_o  = sat_data;
                if (out_ready_i) begin
                    if (n_q == NLast) begin
                        state_d = StDone;
                    end else begin
                        n_d     = n_q + IDX_W'(1);
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            n_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            mac_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            mac_vld_q <= mac_vld_d;
        end
    end

endmodule

// File: tb/tb_dense_mac_seq.sv
// Bench for dense_mac_seq: two instances (FRAC=0 and FRAC=8) share ROM/activation contents
// and are checked against a dot-product model and a table of hand-computed layers.
module tb_dense_mac_seq;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;

    logic clk, rst_n, start, out_ready;

    logic        busy0, done0, rom_en0, act_rd0, out_valid0;
    logic [18:0] rom_addr0;
    logic [1:0]  act_addr0;
    logic [15:0] rom_q0, act_q0, out_data0;
    logic [0:0]  out_idx0;

    logic        busy1, done1, rom_en1, act_rd1, out_valid1;
    logic [18:0] rom_addr1;
    logic [1:0]  act_addr1;
    logic [15:0] rom_q1, act_q1, out_data1;
    logic [0:0]  out_idx1;

    logic signed [15:0] rom_mem [8];
    logic signed [15:0] act_mem [4];
    logic signed [15:0] exp0 [2];
    logic signed [15:0] exp8 [2];

    int checks = 0;
    int failures = 0;

    dense_mac_seq #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .W_W(16), .A_W(16), .ACC_W(40), .FRAC(0),
        .OUT_W(16), .BASE_ADDR(0), .ROM_AW(19)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy0), .done_o(done0),
        .rom_en_o(rom_en0), .rom_addr_o(rom_addr0), .rom_dout_i(rom_q0),
        .act_rd_o(act_rd0), .act_addr_o(act_addr0), .act_data_i(act_q0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
        .out_idx_o(out_idx0)
    );

    dense_mac_seq #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .W_W(16), .A_W(16), .ACC_W(40), .FRAC(8),
        .OUT_W(16), .BASE_ADDR(0), .ROM_AW(19)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy1), .done_o(done1),
        .rom_en_o(rom_en1), .rom_addr_o(rom_addr1), .rom_dout_i(rom_q1),
        .act_rd_o(act_rd1), .act_addr_o(act_addr1), .act_data_i(act_q1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
        .out_idx_o(out_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered, enable-gated memories; out-of-range addresses return a marker value.
    always_ff @(posedge clk) begin
        if (rom_en0) rom_q0 <= (rom_addr0 < 19'd8) ? rom_mem[rom_addr0[2:0]] : 16'h5A5A;
        if (rom_en1) rom_q1 <= (rom_addr1 < 19'd8) ? rom_mem[rom_addr1[2:0]] : 16'h5A5A;
        if (act_rd0) act_q0 <= act_mem[act_addr0];
        if (act_rd1) act_q1 <= act_mem[act_addr1];
    end

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint model(input int n, input int frac);
        longint acc = 0;
        for (int k = 0; k < IN_LEN; k++) begin
            acc += longint'(rom_mem[n*IN_LEN+k]) * longint'(act_mem[k]);
        end
        acc = acc >>> frac;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_rom_en"}, rom_en0, 0);
        chk({tag, "_rom_addr"}, rom_addr0, 0);
        chk({tag, "_act_rd"}, act_rd0, 0);
        chk({tag, "_act_addr"}, act_addr0, 0);
        chk({tag, "_valid"}, out_valid0, 0);
        chk({tag, "_data"}, out_data0, 0);
        chk({tag, "_idx"}, out_idx0, 0);
        chk({tag, "_busy_f8"}, busy1, 0);
    endtask

    // Pulses start, then follows the layer cycle by cycle (cycle 0 = start cycle).
    task automatic run_layer(input int stall, input bit rnd_ready, input bit junk_start,
                             input bit chk_timing);
        int got = 0;
        int dones = 0;
        int first_v = -1;
        int done_cyc = -1;
        int stall_left = stall;
        bit fin = 0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            start = (junk_start && dones == 0 && !done0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (dones == 0) chk("busy_during", busy0, 1);
            if (out_valid0) begin
                if (first_v < 0) first_v = cyc;
                if (got >= OUT_LEN) begin
                    chk("extra_output", got, OUT_LEN - 1);
                end else begin
                    chk("out_idx", out_idx0, got);
                    chk("out_data_f0", $signed(out_data0), exp0[got]);
                    chk("out_data_f8", $signed(out_data1), exp8[got]);
                end
                chk("valid_f8", out_valid1, 1);
                chk("rom_en_in_out", rom_en0, 0);
                chk("act_rd_in_out", act_rd0, 0);
                if (stall_left > 0 && got == 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) got++;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done0) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("outputs_at_done", got, OUT_LEN);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("done_count", dones, 1);
        chk("busy_after", busy0, 0);
        chk("valid_after", out_valid0, 0);
        if (chk_timing) begin
            chk("first_valid_cycle", first_v, IN_LEN + 2);
            chk("done_cycle", done_cyc, 2 * (IN_LEN + 2) + 1);
        end
    endtask

    typedef struct {
        logic [7:0][15:0] w;
        logic [3:0][15:0] a;
        logic [1:0][15:0] e0;
        logic [1:0][15:0] e8;
    } vec_t;

    vec_t tbl [4];

    task automatic load_row(input int r);
        for (int i = 0; i < 8; i++) rom_mem[i] = tbl[r].w[i];
        for (int i = 0; i < 4; i++) act_mem[i] = tbl[r].a[i];
        for (int i = 0; i < 2; i++) begin
            exp0[i] = tbl[r].e0[i];
            exp8[i] = tbl[r].e8[i];
        end
    endtask

    initial begin
        // Weights 1..8, unit activations: neuron sums 10 and 26.
        tbl[0].w  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        tbl[0].a  = {4{16'd1}};
        tbl[0].e0 = {16'd26, 16'd10};
        tbl[0].e8 = {16'd0, 16'd0};
        // 4 * 0x7FFF^2 overflows positive at both shifts.
        tbl[1].w  = {8{16'h7FFF}};
        tbl[1].a  = {4{16'h7FFF}};
        tbl[1].e0 = {16'h7FFF, 16'h7FFF};
        tbl[1].e8 = {16'h7FFF, 16'h7FFF};
        // 4 * (-32768 * 32767) clamps negative.
        tbl[2].w  = {8{16'h8000}};
        tbl[2].a  = {4{16'h7FFF}};
        tbl[2].e0 = {16'h8000, 16'h8000};
        tbl[2].e8 = {16'h8000, 16'h8000};
        // -256 * 1 * 4 = -1024; arithmetic shift by 8 gives -4.
        tbl[3].w  = {8{16'hFF00}};
        tbl[3].a  = {4{16'd1}};
        tbl[3].e0 = {16'hFC00, 16'hFC00};
        tbl[3].e8 = {16'hFFFC, 16'hFFFC};

        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        for (int r = 0; r < 4; r++) begin
            load_row(r);
            run_layer(0, 1'b0, 1'b0, 1'b1);
        end

        load_row(0);
        run_layer(5, 1'b0, 1'b0, 1'b0);
        run_layer(0, 1'b0, 1'b1, 1'b1);

        // Reset during neuron 1's RUN phase, then a clean restart.
        load_row(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_rom_en", rom_en0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_layer(0, 1'b0, 1'b0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 8; i++) begin
                if (it % 2 == 0) rom_mem[i] = 16'($urandom);
                else rom_mem[i] = 16'(int'($urandom_range(0, 600)) - 300);
            end
            for (int i = 0; i < 4; i++) begin
                if (it % 2 == 0) act_mem[i] = 16'($urandom);
                else act_mem[i] = 16'(int'($urandom_range(0, 600)) - 300);
            end
            for (int n = 0; n < OUT_LEN; n++) begin
                exp0[n] = 16'(model(n, 0));
                exp8[n] = 16'(model(n, 8));
            end
            run_layer((it == 2) ? 3 : 0, it[0], it >= 4, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
